// File: rtl/ap_seq_pkg.sv
// Shared op encodings, FSM state codes and pass-table types for the AP op sequencer.
// Pure definitions, no latency; no flow control.
package ap_seq_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLR_CMP  = 3'd1;
  localparam logic [2:0] S_CLR_WAIT = 3'd2;
  localparam logic [2:0] S_CLR_WR   = 3'd3;
  localparam logic [2:0] S_CMP      = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_WR       = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  // One pass: key/mask bits for a_i, b_i, cr; write bits and enables for b_i and C.
  // c_at_bit selects C bit i (logic ops) versus the carry slot C[0] (ADD).
  typedef struct packed {
    logic ka, kb, kc;
    logic ma, mb, mc;
    logic wb, wc;
    logic web, wec;
    logic c_at_bit;
  } pass_ent_t;

  function automatic logic [2:0] num_passes(input logic [1:0] op);
    case (op)
      OP_AND:  return 3'd1;
      OP_OR:   return 3'd3;
      OP_XOR:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ap_pass_rom.sv
// Pass table: (op, pass, bit) -> CAM key/mask and write vectors, shifted to bit i.
// Combinational, zero latency; no flow control.
module ap_pass_rom
  import ap_seq_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CW        = $clog2(WORD_SIZE) + 1
) (
  input  logic [1:0]           op,
  input  logic [1:0]           pass_cnt,
  input  logic [CW-1:0]        bit_cnt,
  output logic [WORD_SIZE-1:0] key_a,
  output logic [WORD_SIZE-1:0] key_b,
  output logic [WORD_SIZE-1:0] key_c,
  output logic [WORD_SIZE-1:0] mask_a,
  output logic [WORD_SIZE-1:0] mask_b,
  output logic [WORD_SIZE-1:0] mask_c,
  output logic [WORD_SIZE-1:0] wr_val_b,
  output logic [WORD_SIZE-1:0] wr_val_c,
  output logic [WORD_SIZE-1:0] wr_mask_b,
  output logic [WORD_SIZE-1:0] wr_mask_c
);

  pass_ent_t             e;
  logic [2:0]            pat;
  logic [WORD_SIZE-1:0]  bit_sel;
  logic [WORD_SIZE-1:0]  c_sel;

  always_comb begin
    e   = '0;
    pat = 3'b000;
    e.ma = 1'b1;
    e.mb = 1'b1;
    if (op == OP_ADD) begin
      e.mc  = 1'b1;
      e.web = 1'b1;
      e.wec = 1'b1;
      // Ordered so a row rewritten by one pass never matches a later pass of the same bit.
      case (pass_cnt)
        2'd0:    begin pat = 3'b001; e.wb = 1'b1; e.wc = 1'b0; end
        2'd1:    begin pat = 3'b011; e.wb = 1'b0; e.wc = 1'b1; end
        2'd2:    begin pat = 3'b110; e.wb = 1'b0; e.wc = 1'b1; end
        default: begin pat = 3'b100; e.wb = 1'b1; e.wc = 1'b0; end
      endcase
    end else begin
      e.wc       = 1'b1;
      e.wec      = 1'b1;
      e.c_at_bit = 1'b1;
      case (op)
        OP_AND:  pat = 3'b110;
        OP_OR:   pat = (pass_cnt == 2'd0) ? 3'b010 : (pass_cnt == 2'd1) ? 3'b100 : 3'b110;
        default: pat = (pass_cnt == 2'd0) ? 3'b010 : 3'b100;
      endcase
    end
    e.ka = pat[2];
    e.kb = pat[1];
    e.kc = pat[0];
  end

  assign bit_sel = WORD_SIZE'(1) << bit_cnt;
  assign c_sel   = e.c_at_bit ? bit_sel : WORD_SIZE'(1);

  assign key_a     = e.ka  ? bit_sel : '0;
  assign key_b     = e.kb  ? bit_sel : '0;
  assign key_c     = e.kc  ? c_sel   : '0;
  assign mask_a    = e.ma  ? bit_sel : '0;
  assign mask_b    = e.mb  ? bit_sel : '0;
  assign mask_c    = e.mc  ? c_sel   : '0;
  assign wr_val_b  = e.wb  ? bit_sel : '0;
  assign wr_mask_b = e.web ? bit_sel : '0;
  assign wr_val_c  = e.wc  ? c_sel   : '0;
  assign wr_mask_c = e.wec ? c_sel   : '0;

endmodule

// File: rtl/ap_op_sequencer.sv
// Bit-serial AND/OR/XOR/ADD sequencer over CAM columns A/B/C; (1+P*W)*(CMP_LAT+2)+1 cycles.
// No backpressure: start ignored while busy, abort returns to IDLE on the next edge.
module ap_op_sequencer
  import ap_seq_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CMP_LAT   = 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 abort,
  input  logic                 irq_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 irq,
  output logic                 cmp_en,
  output logic [WORD_SIZE-1:0] key_a,
  output logic [WORD_SIZE-1:0] key_b,
  output logic [WORD_SIZE-1:0] key_c,
  output logic [WORD_SIZE-1:0] mask_a,
  output logic [WORD_SIZE-1:0] mask_b,
  output logic [WORD_SIZE-1:0] mask_c,
  output logic                 wr_en,
  output logic [WORD_SIZE-1:0] wr_val_b,
  output logic [WORD_SIZE-1:0] wr_val_c,
  output logic [WORD_SIZE-1:0] wr_mask_b,
  output logic [WORD_SIZE-1:0] wr_mask_c
);

  localparam int CW = $clog2(WORD_SIZE) + 1;
  localparam int LW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  logic [2:0]             state, state_nx;
  logic [1:0]             op_q, pass_cnt;
  logic [CW-1:0]          bit_cnt;
  logic [LW-1:0]          lat_cnt;
  logic                   irq_q;
  logic                   last_pass, last_bit, lat_done, in_wait;
  logic [6*WORD_SIZE-1:0] keys_q, keys_rom, keys;
  logic [WORD_SIZE-1:0]   r_key_a, r_key_b, r_key_c, r_mask_a, r_mask_b, r_mask_c;
  logic [WORD_SIZE-1:0]   r_wr_val_b, r_wr_val_c, r_wr_mask_b, r_wr_mask_c;

  ap_pass_rom #(.WORD_SIZE(WORD_SIZE), .CW(CW)) u_rom (
    .op        (op_q),
    .pass_cnt  (pass_cnt),
    .bit_cnt   (bit_cnt),
    .key_a     (r_key_a),
    .key_b     (r_key_b),
    .key_c     (r_key_c),
    .mask_a    (r_mask_a),
    .mask_b    (r_mask_b),
    .mask_c    (r_mask_c),
    .wr_val_b  (r_wr_val_b),
    .wr_val_c  (r_wr_val_c),
    .wr_mask_b (r_wr_mask_b),
    .wr_mask_c (r_wr_mask_c)
  );

  assign last_pass = ({1'b0, pass_cnt} == num_passes(op_q) - 3'd1);
  assign last_bit  = (bit_cnt == CW'(WORD_SIZE - 1));
  assign lat_done  = (lat_cnt == LW'(CMP_LAT - 1));
  assign in_wait   = (state == S_CLR_WAIT) || (state == S_WAIT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_CLR_CMP;
      S_CLR_CMP:  state_nx = S_CLR_WAIT;
      S_CLR_WAIT: if (lat_done) state_nx = S_CLR_WR;
      S_CLR_WR:   state_nx = S_CMP;
      S_CMP:      state_nx = S_WAIT;
      S_WAIT:     if (lat_done) state_nx = S_WR;
      S_WR:       state_nx = (last_pass && last_bit) ? S_DONE : S_CMP;
      default:    state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      pass_cnt <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      irq_q    <= 1'b0;
      keys_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) op_q <= op;
      // Restarts from zero whenever a wait state is entered fresh, including after abort.
      lat_cnt <= (in_wait && state_nx == state) ? lat_cnt + LW'(1) : '0;
      if (state == S_CLR_WR) begin
        pass_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state == S_WR) begin
        if (last_pass) begin
          pass_cnt <= '0;
          bit_cnt  <= bit_cnt + CW'(1);
        end else begin
          pass_cnt <= pass_cnt + 2'd1;
        end
      end
      if (cmp_en) keys_q <= keys;
      if (state == S_DONE) irq_q <= 1'b1;
      else if (irq_clr)    irq_q <= 1'b0;
    end
  end

  assign keys_rom = {r_key_a, r_key_b, r_key_c, r_mask_a, r_mask_b, r_mask_c};

  always_comb begin
    keys = keys_q;
    if (state == S_CMP)          keys = keys_rom;
    else if (state == S_CLR_CMP) keys = '0;
  end

  assign {key_a, key_b, key_c, mask_a, mask_b, mask_c} = keys;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign irq       = irq_q | done;
  assign cmp_en    = (state == S_CMP) || (state == S_CLR_CMP);
  assign wr_en     = (state == S_WR) || (state == S_CLR_WR);
  assign wr_val_b  = (state == S_WR) ? r_wr_val_b  : '0;
  assign wr_mask_b = (state == S_WR) ? r_wr_mask_b : '0;
  assign wr_val_c  = (state == S_WR) ? r_wr_val_c  : '0;
  assign wr_mask_c = (state == S_WR) ? r_wr_mask_c : ((state == S_CLR_WR) ? '1 : '0);

endmodule

// File: tb/tb_ap_op_sequencer.sv
// Bench for ap_op_sequencer: drives ops against a small CAM model, checks results
// against plain-arithmetic expectations, latency, write counts and control boundaries.
module tb_ap_op_sequencer;

  localparam int W  = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort, irq_clr, start3;
  logic [1:0]   op, op3;
  logic         busy, done, irq, cmp_en, wr_en;
  logic [W-1:0] key_a, key_b, key_c, mask_a, mask_b, mask_c;
  logic [W-1:0] wr_val_b, wr_val_c, wr_mask_b, wr_mask_c;
  logic         busy3, done3, irq3, cmp_en3, wr_en3;
  logic [W-1:0] key_a3, key_b3, key_c3, mask_a3, mask_b3, mask_c3;
  logic [W-1:0] wr_val_b3, wr_val_c3, wr_mask_b3, wr_mask_c3;
  logic [10*W+4:0] outs_all;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] cam_a[NR], cam_b[NR], cam_c[NR], ra[NR], rb[NR];

  ap_op_sequencer #(.WORD_SIZE(W), .CMP_LAT(1)) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .op(op), .abort(abort), .irq_clr(irq_clr),
    .busy(busy), .done(done), .irq(irq), .cmp_en(cmp_en),
    .key_a(key_a), .key_b(key_b), .key_c(key_c), .mask_a(mask_a), .mask_b(mask_b), .mask_c(mask_c),
    .wr_en(wr_en), .wr_val_b(wr_val_b), .wr_val_c(wr_val_c), .wr_mask_b(wr_mask_b), .wr_mask_c(wr_mask_c)
  );

  ap_op_sequencer #(.WORD_SIZE(W), .CMP_LAT(3)) dut3 (
    .CLK100MHZ(clk), .rst_n(rst_n), .start(start3), .op(op3), .abort(abort), .irq_clr(irq_clr),
    .busy(busy3), .done(done3), .irq(irq3), .cmp_en(cmp_en3),
    .key_a(key_a3), .key_b(key_b3), .key_c(key_c3), .mask_a(mask_a3), .mask_b(mask_b3), .mask_c(mask_c3),
    .wr_en(wr_en3), .wr_val_b(wr_val_b3), .wr_val_c(wr_val_c3), .wr_mask_b(wr_mask_b3), .wr_mask_c(wr_mask_c3)
  );

  assign outs_all = {busy, done, irq, cmp_en, wr_en, key_a, key_b, key_c, mask_a, mask_b, mask_c,
                     wr_val_b, wr_val_c, wr_mask_b, wr_mask_c};

  // Expected {B, C} of a row after an op; C was cleared first, so ADD leaves only the carry.
  function automatic logic [2*W-1:0] ref_row(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (o)
      2'd0:    return {b, a & b};
      2'd1:    return {b, a | b};
      2'd2:    return {b, a ^ b};
      default: return {s[W-1:0], {(W-1){1'b0}}, s[W]};
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input int lat);
    int p;
    p = (o == 2'd0) ? 1 : (o == 2'd1) ? 3 : (o == 2'd2) ? 2 : 4;
    return (1 + p * W) * (lat + 2) + 1;
  endfunction

  task automatic load_cam;
    for (int r = 0; r < NR; r++) begin
      cam_a[r] = ra[r];
      cam_b[r] = rb[r];
      cam_c[r] = W'($urandom);
    end
  endtask

  task automatic random_rows;
    for (int r = 0; r < NR; r++) begin
      ra[r] = W'($urandom);
      rb[r] = W'($urandom);
    end
  endtask

  // Runs one op on the main DUT while acting as the CAM; lat = 0 means it never finished.
  task automatic exec_op(input logic [1:0] o, input bit hold, output int lat, output int nwr, output bit stable);
    logic [NR-1:0]  tag;
    logic [6*W-1:0] kq;
    lat = 0; nwr = 0; stable = 1'b1; tag = '0; kq = '0;
    @(negedge clk);
    op = o;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (cmp_en) begin
        kq = {key_a, key_b, key_c, mask_a, mask_b, mask_c};
        for (int r = 0; r < NR; r++)
          tag[r] = ((((cam_a[r] ^ key_a) & mask_a) | ((cam_b[r] ^ key_b) & mask_b) |
                     ((cam_c[r] ^ key_c) & mask_c)) == '0);
      end else if (busy && kq !== {key_a, key_b, key_c, mask_a, mask_b, mask_c}) begin
        stable = 1'b0;
      end
      if (wr_en) begin
        nwr++;
        for (int r = 0; r < NR; r++)
          if (tag[r]) begin
            cam_b[r] = (cam_b[r] & ~wr_mask_b) | (wr_val_b & wr_mask_b);
            cam_c[r] = (cam_c[r] & ~wr_mask_c) | (wr_val_c & wr_mask_c);
          end
      end
      if (done) begin
        lat = n + 1;
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs_all !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs_all); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || irq !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b irq=%b want 0 0", busy, irq); end
  endtask

  task automatic test_and;
    int lat, nwr; bit st; logic [2*W-1:0] exp;
    random_rows();
    ra[0] = 8'hF0; rb[0] = 8'h3C; ra[1] = 8'hFF; rb[1] = 8'h00;
    load_cam();
    exec_op(2'd0, 1'b0, lat, nwr, st);
    n_cmp++; if (lat !== 28) begin n_err++; $display("FAIL and_latency: got %0d want 28", lat); end
    n_cmp++; if (nwr !== 9) begin n_err++; $display("FAIL and_wr_pulses: got %0d want 9", nwr); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL and_key_stable: got %b want 1", st); end
    for (int r = 0; r < NR; r++) begin
      exp = ref_row(2'd0, ra[r], rb[r]);
      n_cmp++;
      if ({cam_b[r], cam_c[r]} !== exp) begin
        n_err++; $display("FAIL and_row%0d: got B=%h C=%h want B=%h C=%h", r, cam_b[r], cam_c[r], exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_xor_or;
    int lat, nwr; bit st; logic [2*W-1:0] exp;
    logic [1:0] o;
    int want;
    random_rows();
    ra[0] = 8'hA5; rb[0] = 8'h5A; ra[1] = 8'h0F; rb[1] = 8'h0F;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? 2'd2 : 2'd1;
      want = (k == 0) ? 52 : 76;
      load_cam();
      exec_op(o, 1'b0, lat, nwr, st);
      n_cmp++; if (lat !== want) begin n_err++; $display("FAIL op%0d_latency: got %0d want %0d", o, lat, want); end
      for (int r = 0; r < NR; r++) begin
        exp = ref_row(o, ra[r], rb[r]);
        n_cmp++;
        if ({cam_b[r], cam_c[r]} !== exp) begin
          n_err++; $display("FAIL op%0d_row%0d: got B=%h C=%h want B=%h C=%h", o, r, cam_b[r], cam_c[r], exp[2*W-1:W], exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_add;
    int lat, nwr; bit st; logic [2*W-1:0] exp;
    random_rows();
    ra[0] = 8'h01; rb[0] = 8'hFF; ra[1] = 8'h7F; rb[1] = 8'h01; ra[2] = 8'h00; rb[2] = 8'h00;
    load_cam();
    exec_op(2'd3, 1'b0, lat, nwr, st);
    n_cmp++; if (lat !== 100) begin n_err++; $display("FAIL add_latency: got %0d want 100", lat); end
    n_cmp++; if (nwr !== 33) begin n_err++; $display("FAIL add_wr_pulses: got %0d want 33", nwr); end
    for (int r = 0; r < NR; r++) begin
      exp = ref_row(2'd3, ra[r], rb[r]);
      n_cmp++;
      if ({cam_b[r], cam_c[r]} !== exp) begin
        n_err++; $display("FAIL add_row%0d: got B=%h C=%h want B=%h C=%h", r, cam_b[r], cam_c[r], exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_add;
    int lat, nwr, seen; bit st; logic [2*W-1:0] exp;
    seen = 0;
    @(negedge clk);
    op = 2'd3;
    start = 1'b1;
    @(posedge clk);
    // Clear pass plus three full bits of four ADD passes each puts the next compare at bit 3.
    for (int n = 0; n < 400 && seen < 13; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en) seen++;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs_all !== '0) begin n_err++; $display("FAIL midreset_outputs: got %h want 0", outs_all); end
    @(negedge clk);
    rst_n = 1'b1;
    random_rows();
    load_cam();
    exec_op(2'd3, 1'b0, lat, nwr, st);
    n_cmp++; if (lat !== 100) begin n_err++; $display("FAIL midreset_add_latency: got %0d want 100", lat); end
    for (int r = 0; r < NR; r++) begin
      exp = ref_row(2'd3, ra[r], rb[r]);
      n_cmp++;
      if ({cam_b[r], cam_c[r]} !== exp) begin
        n_err++; $display("FAIL midreset_row%0d: got B=%h C=%h want B=%h C=%h", r, cam_b[r], cam_c[r], exp[2*W-1:W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_cmp_lat3;
    int lat, nwr; bit st, clr_ok;
    logic [6*W-1:0] kq;
    lat = 0; nwr = 0; st = 1'b1; clr_ok = 1'b0; kq = '0;
    @(negedge clk);
    op3 = 2'd0;
    start3 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (cmp_en3) kq = {key_a3, key_b3, key_c3, mask_a3, mask_b3, mask_c3};
      else if (busy3 && kq !== {key_a3, key_b3, key_c3, mask_a3, mask_b3, mask_c3}) st = 1'b0;
      if (wr_en3) begin
        if (nwr == 0) clr_ok = (wr_mask_c3 == '1) && (wr_val_c3 == '0) && (wr_mask_b3 == '0);
        nwr++;
      end
      if (done3) begin
        lat = n + 1;
        break;
      end
    end
    n_cmp++; if (lat !== 46) begin n_err++; $display("FAIL lat3_latency: got %0d want 46", lat); end
    n_cmp++; if (nwr !== 9) begin n_err++; $display("FAIL lat3_wr_pulses: got %0d want 9", nwr); end
    n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL lat3_key_stable: got %b want 1", st); end
    n_cmp++; if (clr_ok !== 1'b1) begin n_err++; $display("FAIL lat3_clear_write: got %b want 1", clr_ok); end
    n_cmp++; if (irq3 !== 1'b1) begin n_err++; $display("FAIL lat3_irq: got %b want 1", irq3); end
  endtask

  task automatic test_hold_start;
    int lat, nwr; bit st;
    random_rows();
    load_cam();
    exec_op(2'd0, 1'b1, lat, nwr, st);
    n_cmp++; if (lat !== 28) begin n_err++; $display("FAIL hold_latency: got %0d want 28", lat); end
    n_cmp++; if (nwr !== 9) begin n_err++; $display("FAIL hold_wr_pulses: got %0d want 9", nwr); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL hold_idle_after: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_abort;
    int seen; bit woke;
    seen = 0; woke = 1'b0;
    @(negedge clk);
    op = 2'd2;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (cmp_en) seen++;
      if (seen == 2) break;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (seen !== 2 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL abort_to_idle: compares=%0d busy=%b done=%b want 2 0 0", seen, busy, done);
    end
    repeat (40) begin
      @(negedge clk);
      if (busy || done) woke = 1'b1;
    end
    n_cmp++; if (woke !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got activity=%b want 0", woke); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL abort_keeps_irq: got %b want 1", irq); end
  endtask

  task automatic test_irq;
    int lat, nwr; bit st;
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    random_rows();
    load_cam();
    // irq_clr stays high across DONE; the set must win.
    exec_op(2'd0, 1'b0, lat, nwr, st);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_beats_clr: got %b want 1", irq); end
    irq_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_held: got %b want 1", irq); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr_pulse: got %b want 0", irq); end
  endtask

  task automatic test_random;
    int lat, nwr; bit st; logic [2*W-1:0] exp;
    logic [1:0] o;
    for (int k = 0; k < 8; k++) begin
      o = 2'($urandom_range(0, 3));
      random_rows();
      load_cam();
      exec_op(o, 1'b0, lat, nwr, st);
      n_cmp++;
      if (lat !== ref_lat(o, 1)) begin n_err++; $display("FAIL rand%0d_latency: op=%0d got %0d want %0d", k, o, lat, ref_lat(o, 1)); end
      for (int r = 0; r < NR; r++) begin
        exp = ref_row(o, ra[r], rb[r]);
        n_cmp++;
        if ({cam_b[r], cam_c[r]} !== exp) begin
          n_err++; $display("FAIL rand%0d_row%0d: op=%0d got B=%h C=%h want B=%h C=%h", k, r, o, cam_b[r], cam_c[r], exp[2*W-1:W], exp[W-1:0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; abort = 1'b0; irq_clr = 1'b0; start3 = 1'b0; op3 = 2'd0;
    test_reset();
    test_and();
    test_reset_mid_add();
    test_xor_or();
    test_add();
    test_cmp_lat3();
    test_hold_start();
    test_abort();
    test_irq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ap_op_sequencer.md
Name: ap_op_sequencer

Overview:
- Bit-serial controller for the associative processor's three CAM columns (A, B, C).
- Takes one operation request (AND/OR/XOR/ADD) and runs one clear pass.
- Then, for each bit i = 0..WORD_SIZE-1, runs that op's compare/write passes: drive key+mask, wait CAM tag latency, write tagged rows.
- Replaces ad-hoc sequencing inside the array wrapper; raises done/irq on completion.

Parameters:
WORD_SIZE, 8, bits per CAM word; bit counter width clog2(WORD_SIZE)+1
CMP_LAT, 1, cycles from cmp_en to tags valid in the CAM (>=1)

Ports:
CLK100MHZ  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  0=AND 1=OR 2=XOR 3=ADD; latched on accepted start
abort  in  1  return to IDLE next cycle, no done
irq_clr  in  1  clears irq
busy  out  1  high from cycle after accepted start through DONE
done  out  1  one-cycle pulse in DONE
irq  out  1  set in DONE, held until irq_clr
cmp_en  out  1  compare strobe, one cycle per pass
key_a, key_b, key_c  out  WORD_SIZE  compare keys
mask_a, mask_b, mask_c  out  WORD_SIZE  1 = bit participates in compare
wr_en  out  1  write strobe to all tagged rows
wr_val_b, wr_val_c  out  WORD_SIZE  data written to tagged rows
wr_mask_b, wr_mask_c  out  WORD_SIZE  1 = bit written (all-zero = column untouched)

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; op latch, bit_cnt, pass_cnt = 0. Reset mid-op: same; no done, irq cleared.
- States: IDLE, CLR_CMP, CLR_WAIT, CLR_WR, CMP, WAIT, WR, DONE.
- IDLE: start=1 -> latch op -> CLR_CMP.
- CLR_CMP: cmp_en=1; all masks 0, so every row matches.
- CLR_WAIT: CMP_LAT cycles.
- CLR_WR: wr_en=1, wr_mask_c=all ones, wr_val_c=0; bit_cnt=0, pass_cnt=0; -> CMP.
- CMP: cmp_en=1; key/mask from pass table entry [op][pass_cnt] at bit i = bit_cnt; -> WAIT.
- WAIT: CMP_LAT cycles; keys/masks held stable; -> WR.
- WR: wr_en=1 with the entry's write fields.
  - If pass_cnt = P(op)-1: pass_cnt=0 and bit_cnt+1.
  - Else: pass_cnt+1.
  - If bit_cnt was WORD_SIZE-1 and last pass: -> DONE; else -> CMP.
- DONE: done=1, irq=1, busy=1 -> IDLE.
- Pass tables (pattern a_i b_i, or a_i b_i cr; cr = C[0]):
  - AND (P=1): pattern 11.
  - OR (P=3): patterns 01, 10, 11.
  - XOR (P=2): patterns 01, 10.
  - Logic-op compare: mask_a = mask_b = 1<<i. Logic-op write: wr_val_c = wr_mask_c = 1<<i.
  - ADD (P=4), in-place B <= A+B mod 2^W, carry-out left in C[0]; order fixed: 001, 011, 110, 100.
  - ADD write pairs (b_i, cr) per pattern: 001->(1,0); 011->(0,1); 110->(0,1); 100->(1,0).
  - ADD compare masks: a_i, b_i, C[0].
  - This order guarantees no rewritten row re-matches a later pass in the same bit.
- Latency: N = (1 + P*WORD_SIZE)*(CMP_LAT+2) + 1 cycles.
  - Measured from the start-sampling edge to the edge where done is high.
  - Examples at W=8, CMP_LAT=1: AND 28, OR 76, XOR 52, ADD 100.
- Precedence and boundaries:
  - start while busy: ignored.
  - abort has priority over every state transition, including DONE; it does not clear irq.
  - irq_clr and DONE in the same cycle: irq ends set.
  - Outside CMP/CLR_CMP, WAIT and the write states: keys/masks hold their last values; cmp_en=0, wr_en=0.

Decomposition:
- Package ap_seq_pkg:
  - op encodings and state enum;
  - P(op) constant function;
  - pass-table entry struct: key/mask bits for a, b, cr; write bits for b_i and cr; b/c write enables.
- Sub-module ap_pass_rom: combinational (op, pass_cnt, bit_cnt) -> key/mask/write vectors, shifted to bit i.
- FSM and counters stay in ap_op_sequencer.

Test Plan:
- Reset mid-ADD at bit 3 -> all outputs 0 within the reset cycle; a new start afterwards completes normally with done at cycle 100.
- op=AND on CAM-model rows (A,B) = (0xF0,0x3C),(0xFF,0x00) -> C = 0x30, 0x00; done at cycle 28; exactly 9 wr_en pulses.
- op=XOR and op=OR on rows (0xA5,0x5A),(0x0F,0x0F): XOR -> C = 0xFF, 0x00; OR -> C = 0xFF, 0x0F; done at cycles 52 and 76.
- op=ADD on rows (0x01,0xFF),(0x7F,0x01),(0x00,0x00) -> B = 0x00, 0x80, 0x00; C[0] = 1, 0, 0; done at cycle 100.
- CMP_LAT=3, op=AND -> 5 cycles per pass; done at cycle 46; keys stable through WAIT.
- start held high through an op -> no second run. abort in WAIT -> IDLE next cycle, no done. irq set after done; irq_clr -> 0.
